// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: instruction word layout, default memory depth and
// a helper that packs instruction fields into a word for program images.
package fetch_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_LD  = 4'd6,
    OP_ST  = 4'd7,
    OP_BEQ = 4'd8,
    OP_JMP = 4'd9
  } opcode_t;

  typedef logic [3:0]  reg_t;
  typedef logic [15:0] imm_t;

  typedef struct packed {
    opcode_t op;
    reg_t    rd;
    reg_t    rs1;
    reg_t    rs2;
    imm_t    imm;
  } instruction_t;

  localparam int DEFAULT_DEPTH = 16;

  function automatic instruction_t make_instr(input opcode_t op, input reg_t rd,
                                              input reg_t rs1, input reg_t rs2,
                                              input imm_t imm);
    instruction_t w;
    w.op  = op;
    w.rd  = rd;
    w.rs1 = rs1;
    w.rs2 = rs2;
    w.imm = imm;
    return w;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x WORD_WIDTH storage, one write port and one registered read port.
// Read-before-write on same-address collision; no reset, contents survive arstn.
module instr_mem_array #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_BITS-1:0]  i_wr_addr,
  input  logic [WORD_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_BITS-1:0]  i_rd_addr,
  output logic [WORD_WIDTH-1:0] o_rd_data
);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];
  logic [WORD_WIDTH-1:0] r_rd_data_p1;

  // Both ports sample r_mem before this edge's write lands, giving old data.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data_p1 <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data_p1;

endmodule

// File: rtl/instr_mem.sv
// Writable instruction memory with valid/ready fetch handshake, a single
// response register, flush on branch redirect and address range checking.
module instr_mem
  import fetch_pkg::*;
#(
  parameter int WORD_WIDTH = $bits(instruction_t),
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_BITS-1:0]  req_addr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WORD_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_BITS-1:0]  wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i
);

  localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS + 1)'(DEPTH);

  logic                  w_accept;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic [WORD_WIDTH-1:0] w_rd_data;

  logic                  r_vld_p1;
  logic                  r_err_p1;
  logic                  r_hit_p1;

  assign req_ready_o   = !r_vld_p1 || rsp_ready_i || flush_i;
  assign w_accept      = req_valid_i && req_ready_o;
  assign w_rd_in_range = ({1'b0, req_addr_i} < DEPTH_L);
  assign w_wr_in_range = ({1'b0, wr_addr_i} < DEPTH_L);

  instr_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (wr_en_i && w_wr_in_range),
    .i_wr_addr (wr_addr_i),
    .i_wr_data (wr_data_i),
    .i_rd_en   (w_accept && w_rd_in_range),
    .i_rd_addr (req_addr_i),
    .o_rd_data (w_rd_data)
  );

  // Response stage: r_hit_p1 gates the array word so reset and
  // out-of-range responses read as zero without resetting the storage.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_vld_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
      r_hit_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
      r_err_p1 <= !w_rd_in_range;
      r_hit_p1 <= w_rd_in_range;
    end else if ((r_vld_p1 && rsp_ready_i) || flush_i) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid_o = r_vld_p1;
  assign rsp_err_o   = r_err_p1;
  assign rsp_data_o  = r_hit_p1 ? w_rd_data : '0;

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem (DEPTH=11): directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_instr_mem;
  import fetch_pkg::*;

  localparam int DEPTH = 11;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         arstn;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [3:0]   req_addr_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [W-1:0] rsp_data_o;
  logic         rsp_err_o;
  logic         flush_i;
  logic         wr_en_i;
  logic [3:0]   wr_addr_i;
  logic [W-1:0] wr_data_i;

  always #5 clk = ~clk;

  instr_mem #(.WORD_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .flush_i     (flush_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] m_mem [DEPTH];
  logic         m_valid;
  logic         m_err;
  logic [W-1:0] m_data;
  instruction_t prog [DEPTH];

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    chk_bit({tag, ".rsp_valid"}, rsp_valid_o, m_valid);
    chk_bit({tag, ".rsp_err"}, rsp_err_o, m_err);
    chk_word({tag, ".rsp_data"}, rsp_data_o, m_data);
  endtask

  // One clock cycle: drive at posedge+1, check ready before the edge,
  // advance the model, check the response register after the edge.
  task automatic step(input string tag, input logic rv, input logic [3:0] ra,
                      input logic rr, input logic fl, input logic we,
                      input logic [3:0] wa, input logic [W-1:0] wd);
    logic exp_ready;
    logic acc;
    req_valid_i = rv;
    req_addr_i  = ra;
    rsp_ready_i = rr;
    flush_i     = fl;
    wr_en_i     = we;
    wr_addr_i   = wa;
    wr_data_i   = wd;
    #1;
    exp_ready = !m_valid || rr || fl;
    chk_bit({tag, ".req_ready"}, req_ready_o, exp_ready);
    acc = rv && exp_ready;
    if (acc) begin
      m_valid = 1'b1;
      m_err   = (int'(ra) >= DEPTH);
      m_data  = m_err ? '0 : m_mem[ra];
    end else if ((m_valid && rr) || fl) begin
      m_valid = 1'b0;
    end
    if (we && int'(wa) < DEPTH) m_mem[wa] = wd;
    @(posedge clk);
    #1;
    check_rsp(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, '0);
  endtask

  initial begin
    prog[0]  = make_instr(OP_MOV, 4'd0, 4'd0, 4'd0, 16'd4);
    prog[1]  = make_instr(OP_MOV, 4'd1, 4'd0, 4'd0, 16'd9);
    prog[2]  = make_instr(OP_SUB, 4'd3, 4'd1, 4'd0, 16'd0);
    prog[3]  = make_instr(OP_AND, 4'd4, 4'd3, 4'd1, 16'd0);
    prog[4]  = make_instr(OP_OR,  4'd5, 4'd4, 4'd2, 16'd0);
    prog[5]  = make_instr(OP_ADD, 4'd2, 4'd0, 4'd1, 16'd0);
    prog[6]  = make_instr(OP_LD,  4'd6, 4'd2, 4'd0, 16'h0010);
    prog[7]  = make_instr(OP_ST,  4'd0, 4'd2, 4'd6, 16'h0020);
    prog[8]  = make_instr(OP_BEQ, 4'd0, 4'd6, 4'd5, 16'hFFFC);
    prog[9]  = make_instr(OP_JMP, 4'd0, 4'd0, 4'd0, 16'h0100);
    prog[10] = make_instr(OP_NOP, 4'd0, 4'd0, 4'd0, 16'h0000);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_data  = '0;

    arstn = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b0; flush_i = 1'b0;
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    #3;
    chk_bit("reset.req_ready", req_ready_o, 1'b1);
    check_rsp("reset");
    @(posedge clk);
    #3 arstn = 1'b1;
    @(posedge clk);
    #1;
    check_rsp("post_reset");

    // Load the whole program image.
    for (int i = 0; i < DEPTH; i++)
      step("load", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'(i), W'(prog[i]));

    // Back-to-back reads, one response per cycle.
    for (int i = 0; i < 10; i++)
      step("stream", 1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 4'd0, '0);
    idle("stream_drain");

    // Stall with a held response, then take and accept in the same cycle.
    step("stall_acc", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    for (int i = 0; i < 4; i++)
      step("stall_hold", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk_word("stall_word3", rsp_data_o, W'(prog[3]));
    step("stall_release", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, '0);
    chk_word("release_word5", rsp_data_o, W'(prog[5]));
    idle("stall_drain");

    // Out-of-range read and ignored out-of-range writes.
    step("oor_read", 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 4'd0, '0);
    chk_bit("oor_err_const", rsp_err_o, 1'b1);
    step("oor_wr12", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd12, 32'hDEADBEEF);
    step("oor_wr11", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd11, 32'hCAFEF00D);
    for (int i = 0; i < DEPTH; i++)
      step("oor_reread", 1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 4'd0, '0);
    idle("oor_drain");

    // Same-cycle read and write of one address returns the old word.
    step("col_pre", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h11);
    step("col_rw", 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 4'd2, 32'hA5);
    chk_word("col_old", rsp_data_o, 32'h11);
    step("col_new", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, '0);
    chk_word("col_new_const", rsp_data_o, 32'hA5);
    idle("col_drain");

    // Flush with a redirect request, then flush alone.
    step("fl_acc", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("fl_redirect", 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 4'd0, '0);
    chk_word("fl_word7", rsp_data_o, W'(prog[7]));
    step("fl_only", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, '0);
    chk_bit("fl_only_const", rsp_valid_o, 1'b0);

    // Random traffic on every input.
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(1, 0) == 1, 4'($urandom_range(15, 0)),
           $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
           $urandom_range(3, 0) == 0, 4'($urandom_range(15, 0)), $urandom());
    idle("rand_drain");

    // Asynchronous reset while a response is held; the array must survive.
    step("ar_acc", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("ar_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    arstn = 1'b0;
    #1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_data  = '0;
    chk_bit("ar_async.req_ready", req_ready_o, 1'b1);
    check_rsp("ar_async");
    @(posedge clk);
    #1;
    check_rsp("ar_held");
    #2 arstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++)
      step("ar_reread", 1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 4'd0, '0);
    idle("ar_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
